// File: rtl/pheap_dispatch_if.sv
// Producer and consumer valid/ready handshakes of the heap dispatch front end.
// The slave modport is the dispatcher; the master modport is the producer/consumer side.
interface pheap_dispatch_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pheap_dispatch.sv
// Front end of the pipelined min-heap: arbitrates enq/deq, enforces the heap settle gap,
// and dispatches the minimum event only while its timestamp is inside the window.
module pheap_dispatch #(
  parameter int WIDTH   = 32,
  parameter int CMP_WID = 32,
  parameter int DEPTH   = 6,
  parameter int GAP     = 1
) (
  input  logic               clk,
  input  logic               rst,
  pheap_dispatch_if.slave    io,
  input  logic [CMP_WID-1:0] win_end,
  output logic               heap_enq,
  output logic               heap_deq,
  output logic [WIDTH-1:0]   heap_data,
  input  logic [WIDTH-1:0]   heap_q,
  input  logic               heap_full,
  input  logic               heap_empty,
  input  logic [DEPTH-1:0]   heap_cnt,
  output logic [15:0]        blk_cnt
);

  logic [1:0]       cool_reg, cool_next;
  logic             pref_reg, pref_next;
  logic             out_valid_reg, out_valid_next;
  logic [WIDTH-1:0] out_data_reg, out_data_next;
  logic [15:0]      blk_cnt_reg, blk_cnt_next;

  logic slot_ok, out_free, win_ok;
  logic deq_ok, enq_ok, in_ready_int;
  logic enq_fire, deq_fire, blocked;

  // Element count is informational only; nothing in the control path relies on it.
  logic unused_heap_cnt;
  assign unused_heap_cnt = ^heap_cnt;

  always_comb begin
    slot_ok      = (cool_reg == 2'd0);
    out_free     = ~out_valid_reg | io.out_ready;
    win_ok       = (heap_q[CMP_WID-1:0] <= win_end);
    // Reset gating keeps every strobe low while rst is held.
    deq_ok       = ~rst & slot_ok & ~heap_empty & out_free & win_ok;
    enq_ok       = ~rst & slot_ok & ~heap_full;
    in_ready_int = enq_ok & ~(deq_ok & ~pref_reg);
    enq_fire     = io.in_valid & in_ready_int;
    deq_fire     = deq_ok & ~enq_fire;
    blocked      = slot_ok & ~heap_empty & out_free & ~win_ok;
  end

  always_comb begin
    cool_next      = cool_reg;
    pref_next      = pref_reg;
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    blk_cnt_next   = blk_cnt_reg;

    if (enq_fire | deq_fire) begin
      cool_next = 2'(GAP);
    end else if (cool_reg != 2'd0) begin
      cool_next = cool_reg - 2'd1;
    end

    // Contention hands priority to whichever side lost this round.
    if (deq_ok & enq_ok & io.in_valid) begin
      pref_next = ~pref_reg;
    end

    if (deq_fire) begin
      out_valid_next = 1'b1;
      out_data_next  = heap_q;
    end else if (out_valid_reg & io.out_ready) begin
      out_valid_next = 1'b0;
    end

    if (blocked && (blk_cnt_reg != 16'hFFFF)) begin
      blk_cnt_next = blk_cnt_reg + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cool_reg      <= 2'd0;
      pref_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      blk_cnt_reg   <= 16'd0;
    end else begin
      cool_reg      <= cool_next;
      pref_reg      <= pref_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      blk_cnt_reg   <= blk_cnt_next;
    end
  end

  assign io.in_ready  = in_ready_int;
  assign io.out_valid = out_valid_reg;
  assign io.out_data  = out_data_reg;
  assign heap_enq     = enq_fire;
  assign heap_deq     = deq_fire;
  assign heap_data    = io.in_data;
  assign blk_cnt      = blk_cnt_reg;

endmodule
